// File: rtl/debounce_multi.sv
// N-channel switch debouncer: 2-flop synchroniser, shared sample-tick prescaler and a per-channel
// consecutive-tick filter with one-cycle rise/fall pulses. Single clock, synchronous reset.
module debounce_multi #(
  parameter int   WIDTH        = 4,
  parameter int   CLK_DIV      = 50000,
  parameter int   STABLE_COUNT = 3,
  parameter logic RESET_VALUE  = 1'b0
) (
  input  logic             clk_crystal,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             sample_tick
);

  localparam int DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CntW = (STABLE_COUNT > 0) ? $clog2(STABLE_COUNT + 1) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_COUNT - 1);

  if (CLK_DIV < 1) begin : gen_bad_clk_div
    $error("debounce_multi: CLK_DIV must be >= 1");
  end
  if (STABLE_COUNT < 1) begin : gen_bad_stable_count
    $error("debounce_multi: STABLE_COUNT must be >= 1");
  end

  logic [DivW-1:0]  div_q, div_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];

  always_comb begin
    div_d  = (div_q == DivMax) ? '0 : div_q + DivW'(1);
    tick_d = (div_q == DivMax);
  end

  // The filter only advances on a tick; a single agreeing sample clears a pending change.
  always_comb begin
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    if (tick_q) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2_q[i] != out_q[i]) begin
          if (cnt_q[i] == CntMax) begin
            out_d[i]  = s2_q[i];
            cnt_d[i]  = '0;
            rise_d[i] = s2_q[i];
            fall_d[i] = ~s2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_crystal) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      s1_q   <= {WIDTH{RESET_VALUE}};
      s2_q   <= {WIDTH{RESET_VALUE}};
      out_q  <= {WIDTH{RESET_VALUE}};
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      s1_q   <= in;
      s2_q   <= s1_q;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out         = out_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign sample_tick = tick_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two instances (typical and degenerate config) checked every cycle
// against a tick-counting behavioural model, plus hand-computed latency and pulse-count checks.
module tb_debounce_multi;

  logic       clk;
  logic       rst_a, rst_b;
  logic [3:0] in_a, in_b;
  logic [3:0] out_a, rise_a, fall_a, out_b, rise_b, fall_b;
  logic       sample_tick_a, sample_tick_b;

  debounce_multi #(
    .WIDTH(4), .CLK_DIV(4), .STABLE_COUNT(3), .RESET_VALUE(1'b0)
  ) dut_a (
    .clk_crystal(clk), .rst(rst_a), .in(in_a), .out(out_a),
    .rise(rise_a), .fall(fall_a), .sample_tick(sample_tick_a)
  );

  debounce_multi #(
    .WIDTH(4), .CLK_DIV(1), .STABLE_COUNT(1), .RESET_VALUE(1'b1)
  ) dut_b (
    .clk_crystal(clk), .rst(rst_b), .in(in_b), .out(out_b),
    .rise(rise_b), .fall(fall_b), .sample_tick(sample_tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: s2 is the input two edges ago; a tick is visible after post-reset edge k when
  // k % CLK_DIV == 0; out flips on the STABLE_COUNT-th consecutive differing tick.
  localparam int DivP [2] = '{4, 1};
  localparam int StabP [2] = '{3, 1};
  localparam bit RvP [2] = '{1'b0, 1'b1};

  logic [3:0] h0 [2], h1 [2], m_out [2], m_rise [2], m_fall [2];
  bit         m_tick [2];
  bit         valid [2] = '{1'b0, 1'b0};
  int         k_cnt [2];
  int         run [2][4];

  task automatic model_step(input int c, input logic r, input logic [3:0] x);
    if (r) begin
      valid[c]  = 1'b1;
      k_cnt[c]  = 0;
      h0[c]     = {4{RvP[c]}};
      h1[c]     = {4{RvP[c]}};
      m_out[c]  = {4{RvP[c]}};
      m_rise[c] = '0;
      m_fall[c] = '0;
      m_tick[c] = 1'b0;
      for (int i = 0; i < 4; i++) run[c][i] = 0;
    end else if (valid[c]) begin
      m_rise[c] = '0;
      m_fall[c] = '0;
      if (m_tick[c]) begin
        for (int i = 0; i < 4; i++) begin
          if (h1[c][i] != m_out[c][i]) begin
            run[c][i]++;
            if (run[c][i] == StabP[c]) begin
              m_out[c][i] = h1[c][i];
              run[c][i]   = 0;
              if (h1[c][i]) m_rise[c][i] = 1'b1;
              else m_fall[c][i] = 1'b1;
            end
          end else begin
            run[c][i] = 0;
          end
        end
      end
      h1[c]     = h0[c];
      h0[c]     = x;
      k_cnt[c]  = k_cnt[c] + 1;
      m_tick[c] = (k_cnt[c] % DivP[c] == 0);
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, in_a);
    model_step(1, rst_b, in_b);
  end

  always @(negedge clk) begin
    if (valid[0]) begin
      check("a.out", {28'b0, out_a}, {28'b0, m_out[0]});
      check("a.rise", {28'b0, rise_a}, {28'b0, m_rise[0]});
      check("a.fall", {28'b0, fall_a}, {28'b0, m_fall[0]});
      check("a.tick", {31'b0, sample_tick_a}, {31'b0, m_tick[0]});
    end
    if (valid[1]) begin
      check("b.out", {28'b0, out_b}, {28'b0, m_out[1]});
      check("b.rise", {28'b0, rise_b}, {28'b0, m_rise[1]});
      check("b.fall", {28'b0, fall_b}, {28'b0, m_fall[1]});
      check("b.tick", {31'b0, sample_tick_b}, {31'b0, m_tick[1]});
    end
  end

  int rise_a_n [4] = '{0, 0, 0, 0};
  int fall_a_n [4] = '{0, 0, 0, 0};
  int rise_b_n [4] = '{0, 0, 0, 0};
  int fall_b_n [4] = '{0, 0, 0, 0};

  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rise_a[i] === 1'b1) rise_a_n[i]++;
      if (fall_a[i] === 1'b1) fall_a_n[i]++;
      if (rise_b[i] === 1'b1) rise_b_n[i]++;
      if (fall_b[i] === 1'b1) fall_b_n[i]++;
    end
  end

  int lat;
  int ticks;
  int rs [4];
  int fs [4];

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    in_a  = 4'h0;
    in_b  = 4'hF;

    // Reset both instances for three edges, then idle.
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    check("rst.out_a", {28'b0, out_a}, 32'h0);
    check("rst.out_b", {28'b0, out_b}, 32'hF);
    check("rst.tick_a", {31'b0, sample_tick_a}, 32'h0);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 3) check("idle.tick3", {31'b0, sample_tick_a}, 32'h0);
      if (k == 4) check("idle.tick4", {31'b0, sample_tick_a}, 32'h1);
      if (k == 5) check("idle.tick5", {31'b0, sample_tick_a}, 32'h0);
      if (k == 8) check("idle.tick8", {31'b0, sample_tick_a}, 32'h1);
    end
    check("idle.out", {28'b0, out_a}, 32'h0);
    check("idle.pulses", rise_a_n[0] + rise_a_n[1] + rise_a_n[2] + rise_a_n[3]
          + fall_a_n[0] + fall_a_n[1] + fall_a_n[2] + fall_a_n[3], 32'd0);

    // Press after edge 100: s2 valid at 102, filter ticks at 105/109/113 -> 13 edges.
    in_a[0] = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (lat == 0 && out_a[0] === 1'b1) lat = n;
    end
    check("press.latency", lat, 32'd13);
    check("press.rise_n", rise_a_n[0], 32'd1);
    check("press.out", {28'b0, out_a}, 32'h1);

    in_a[0] = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (lat == 0 && out_a[0] === 1'b0) lat = n;
    end
    check("release.latency", lat, 32'd13);
    check("release.fall_n", fall_a_n[0], 32'd1);
    check("release.out", {28'b0, out_a}, 32'h0);
    check("release.others", rise_a_n[1] + rise_a_n[2] + rise_a_n[3], 32'd0);

    // Period-6 bounce against a 4-cycle tick never yields three agreeing ticks.
    for (int j = 0; j < 10; j++) begin
      in_a[1] = (j % 2 == 0);
      repeat (3) @(negedge clk);
    end
    check("bounce.out", {28'b0, out_a}, 32'h0);
    check("bounce.pulses", rise_a_n[1] + fall_a_n[1], 32'd0);
    in_a[1] = 1'b1;
    repeat (30) @(negedge clk);
    check("settle.out", {28'b0, out_a}, 32'h2);
    check("settle.rise_n", rise_a_n[1], 32'd1);

    // Multi-channel: channel 3 is high for only 6 cycles, too short for three ticks.
    in_a = 4'h0;
    repeat (30) @(negedge clk);
    check("multi.pre_out", {28'b0, out_a}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rs[i] = rise_a_n[i];
      fs[i] = fall_a_n[i];
    end
    in_a = 4'b1010;
    repeat (6) @(negedge clk);
    in_a = 4'b0010;
    repeat (40) @(negedge clk);
    check("multi.out", {28'b0, out_a}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      check("multi.rise_n", rise_a_n[i] - rs[i], (i == 1) ? 32'd1 : 32'd0);
      check("multi.fall_n", fall_a_n[i] - fs[i], 32'd0);
    end

    // Reset after two qualifying ticks on channel 2; the count must restart from zero.
    in_a = 4'b0110;
    repeat (2) @(negedge clk);
    ticks = 0;
    for (int g = 0; g < 20 && ticks < 2; g++) begin
      @(negedge clk);
      if (sample_tick_a === 1'b1) ticks++;
    end
    check("midrst.ticks_seen", ticks, 32'd2);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("midrst.out", {28'b0, out_a}, 32'h0);
    check("midrst.tick", {31'b0, sample_tick_a}, 32'h0);
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (lat == 0 && out_a[2] === 1'b1) lat = n;
    end
    check("midrst.latency", lat, 32'd13);
    check("midrst.final_out", {28'b0, out_a}, 32'h6);

    // Degenerate instance: tick every cycle, single-tick filter, reset value 1.
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check("degen.rst_out", {28'b0, out_b}, 32'hF);
    repeat (5) @(negedge clk);
    check("degen.hold_out", {28'b0, out_b}, 32'hF);
    check("degen.no_pulses", rise_b_n[0] + rise_b_n[1] + rise_b_n[2] + rise_b_n[3]
          + fall_b_n[0] + fall_b_n[1] + fall_b_n[2] + fall_b_n[3], 32'd0);
    in_b = 4'hE;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (lat == 0 && out_b[0] === 1'b0) lat = n;
    end
    // Two synchroniser edges, then the filter edge.
    check("degen.latency", lat, 32'd3);
    check("degen.fall_n", fall_b_n[0], 32'd1);
    check("degen.out", {28'b0, out_b}, 32'hE);
    check("degen.rise_n", rise_b_n[0] + rise_b_n[1] + rise_b_n[2] + rise_b_n[3], 32'd0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
